rename_stage: RTL and testbench
===============================

Name: rename_stage

Overview:
Register-rename stage between decode and the reorder buffer.
- Translates each instruction's architectural sources and destination into physical register tags.
- Allocates new destination tags by popping the physical free list in the same cycle.
- Holds a speculative RAT and a committed (retirement) RAT; the committed RAT restores the speculative one on flush.
- One instruction per cycle, with one registered output slot toward the ROB.

Parameters:
- ARCH_REGS, 32, number of architectural registers (x0 hardwired to zero).
- ARCH_W, 5, architectural register index width.
- PHY_W, 7, physical register tag width (matches free list tag width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs1  in  ARCH_W  source 1 architectural index
- in_rs2  in  ARCH_W  source 2 architectural index
- in_rd  in  ARCH_W  destination architectural index
- in_rd_wr  in  1  instruction writes rd
- fl_pop  out  1  pop request to free list
- fl_pop_ok  in  1  free list non-empty
- fl_phy_rd  in  PHY_W  free list head tag (combinational)
- out_valid  out  1  renamed instruction valid toward ROB
- out_ready  in  1  ROB accepts
- out_ps1  out  PHY_W  physical tag of source 1
- out_ps2  out  PHY_W  physical tag of source 2
- out_pd  out  PHY_W  newly allocated destination tag
- out_old_pd  out  PHY_W  previous mapping of rd (freed by ROB at commit)
- out_ard  out  ARCH_W  architectural rd
- out_rd_wr  out  1  effective destination write (0 when rd==0)
- commit_valid  in  1  ROB retires a destination write
- commit_ard  in  ARCH_W  retired architectural rd
- commit_pd  in  PHY_W  retired physical tag
- flush  in  1  squash all speculative state

Behaviour:
- Reset:
  - both RATs map arch i -> phys i for i = 0..ARCH_REGS-1.
  - out_valid=0; all out_* data outputs =0; fl_pop=0.
- Effective write: wr_eff = in_rd_wr && in_rd != 0. x0 is never renamed and always reads tag 0.
- in_ready = !flush && (!out_valid || out_ready) && (!wr_eff || fl_pop_ok).
- accept = in_valid && in_ready.
- fl_pop = accept && wr_eff. Combinational, same cycle as accept; fl_phy_rd is consumed that cycle.
- On accept, the output slot loads at the next edge (1-cycle latency):
  - out_ps1 / out_ps2 = spec RAT read before this instruction's update, so rs==rd yields the old mapping.
  - out_old_pd = spec_RAT[rd].
  - out_pd = fl_phy_rd if wr_eff, else 0.
  - out_rd_wr = wr_eff; out_ard = in_rd.
  - spec_RAT[rd] <= fl_phy_rd if wr_eff.
- Output hold: out_valid && !out_ready keeps every out_* field stable. With no accept and out_ready=1, out_valid clears.
- Back-to-back: a dependent instruction in the next cycle sees the updated spec RAT. No bypass is needed because the RAT write completes at the edge.
- Commit: commit_valid && commit_ard != 0 -> comm_RAT[commit_ard] <= commit_pd. A commit to x0 is ignored.
- Flush (priority over accept):
  - spec_RAT <= comm_RAT including any same-cycle commit update, i.e. the flushed copy sees commit_pd.
  - out_valid <= 0; no accept; fl_pop=0.
- Free-list pushes are not generated here; the ROB pushes out_old_pd at commit.
- rst mid-operation returns everything to the reset state regardless of flush, commit or handshakes.

Decomposition:
- Shared package rename_pkg:
  - ARCH_W, PHY_W, ARCH_REGS constants.
  - arch_reg_t and phy_reg_t typedefs.
  - rename_out_t struct for the output slot fields.
- Natural sub-module: rat_table. It holds the spec and committed arrays and provides:
  - 3 combinational read ports;
  - 1 speculative write port;
  - 1 commit write port;
  - a flush-copy input.

Test Plan:
- Reset -> rs1=5, rs2=7, rd=3 with in_rd_wr=1 and fl_phy_rd=32 -> next cycle out_ps1=5, out_ps2=7, out_pd=32, out_old_pd=3, fl_pop pulsed once.
- Chain -> rd=3 (fl=32), then rs1=3 with rd=3 (fl=33) -> second output has out_ps1=32, out_old_pd=32, out_pd=33.
- fl_pop_ok=0 with a writing instruction -> in_ready=0, no pop, output unchanged. Non-writing or rd=0 instruction -> accepted with out_pd=0, out_rd_wr=0, no pop.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Release -> the next instruction lands the following cycle.
- Rename rd=4->40, commit (4,40), rename rd=4->41, flush -> a subsequent rs1=4 reads 40.
- Flush in the same cycle as commit (6,50) -> a subsequent rs1=6 reads 50.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and sizes for the register-rename stage.
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int ARCH_W    = 5;
    localparam int PHY_W     = 7;

    typedef logic [ARCH_W-1:0] arch_reg_t;
    typedef logic [PHY_W-1:0]  phy_reg_t;

    // One renamed instruction as handed to the ROB.
    typedef struct packed {
        phy_reg_t  ps1;
        phy_reg_t  ps2;
        phy_reg_t  pd;
        phy_reg_t  old_pd;
        arch_reg_t ard;
        logic      rd_wr;
    } rename_out_t;
endpackage

// File: rtl/rat_table.sv
// Speculative and committed register alias tables.
// Three combinational speculative reads, one speculative write, one commit
// write, and a flush that reloads the speculative table from the committed one.
module rat_table
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  arch_reg_t i_ra1,
    input  arch_reg_t i_ra2,
    input  arch_reg_t i_ra3,
    output phy_reg_t  o_rd1,
    output phy_reg_t  o_rd2,
    output phy_reg_t  o_rd3,
    input  logic      i_spec_we,
    input  arch_reg_t i_spec_wa,
    input  phy_reg_t  i_spec_wd,
    input  logic      i_comm_we,
    input  arch_reg_t i_comm_wa,
    input  phy_reg_t  i_comm_wd,
    input  logic      i_flush
);
    phy_reg_t r_spec [ARCH_REGS];
    phy_reg_t r_comm [ARCH_REGS];
    phy_reg_t w_comm_next [ARCH_REGS];

    // x0 always reads tag 0, whatever the table holds.
    assign o_rd1 = (i_ra1 == '0) ? '0 : r_spec[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_spec[i_ra2];
    assign o_rd3 = (i_ra3 == '0) ? '0 : r_spec[i_ra3];

    // Committed table including this cycle's retirement; a flush copies this.
    always_comb begin
        w_comm_next = r_comm;
        if (i_comm_we && i_comm_wa != '0)
            w_comm_next[i_comm_wa] = i_comm_wd;
    end

    // Committed table: identity at reset, then tracks retirements.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                r_comm[i] <= phy_reg_t'(i);
        end else begin
            r_comm <= w_comm_next;
        end
    end

    // Speculative table: flush restore wins over a rename write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                r_spec[i] <= phy_reg_t'(i);
        end else if (i_flush) begin
            r_spec <= w_comm_next;
        end else if (i_spec_we && i_spec_wa != '0) begin
            r_spec[i_spec_wa] <= i_spec_wd;
        end
    end
endmodule

// File: rtl/rename_stage.sv
// Register-rename stage between decode and the ROB: one instruction per
// cycle, destination tag popped from the free list on accept, one registered
// output slot.
module rename_stage
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  arch_reg_t in_rs1,
    input  arch_reg_t in_rs2,
    input  arch_reg_t in_rd,
    input  logic      in_rd_wr,
    output logic      fl_pop,
    input  logic      fl_pop_ok,
    input  phy_reg_t  fl_phy_rd,
    output logic      out_valid,
    input  logic      out_ready,
    output phy_reg_t  out_ps1,
    output phy_reg_t  out_ps2,
    output phy_reg_t  out_pd,
    output phy_reg_t  out_old_pd,
    output arch_reg_t out_ard,
    output logic      out_rd_wr,
    input  logic      commit_valid,
    input  arch_reg_t commit_ard,
    input  phy_reg_t  commit_pd,
    input  logic      flush
);
    logic        w_wr_eff;
    logic        w_accept;
    phy_reg_t    w_ps1;
    phy_reg_t    w_ps2;
    phy_reg_t    w_old_pd;
    logic        r_out_valid;
    rename_out_t r_out;

    // x0 is never renamed.
    assign w_wr_eff = in_rd_wr && (in_rd != '0);
    assign in_ready = !flush && (!r_out_valid || out_ready) && (!w_wr_eff || fl_pop_ok);
    assign w_accept = in_valid && in_ready;
    assign fl_pop   = w_accept && w_wr_eff;

    rat_table u_rat (
        .clk       (clk),
        .rst       (rst),
        .i_ra1     (in_rs1),
        .i_ra2     (in_rs2),
        .i_ra3     (in_rd),
        .o_rd1     (w_ps1),
        .o_rd2     (w_ps2),
        .o_rd3     (w_old_pd),
        .i_spec_we (fl_pop),
        .i_spec_wa (in_rd),
        .i_spec_wd (fl_phy_rd),
        .i_comm_we (commit_valid),
        .i_comm_wa (commit_ard),
        .i_comm_wd (commit_pd),
        .i_flush   (flush)
    );

    // Output slot: load on accept, hold while stalled, drop when drained or flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out.ps1    <= w_ps1;
            r_out.ps2    <= w_ps2;
            r_out.old_pd <= w_old_pd;
            r_out.pd     <= w_wr_eff ? fl_phy_rd : '0;
            r_out.ard    <= in_rd;
            r_out.rd_wr  <= w_wr_eff;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ps1    = r_out.ps1;
    assign out_ps2    = r_out.ps2;
    assign out_pd     = r_out.pd;
    assign out_old_pd = r_out.old_pd;
    assign out_ard    = r_out.ard;
    assign out_rd_wr  = r_out.rd_wr;
endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage with an array-based reference model.
module tb_rename_stage;
    logic       clk, rst;
    logic       in_valid, in_ready, in_rd_wr;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic       fl_pop, fl_pop_ok;
    logic [6:0] fl_phy_rd;
    logic       out_valid, out_ready, out_rd_wr;
    logic [6:0] out_ps1, out_ps2, out_pd, out_old_pd;
    logic [4:0] out_ard;
    logic       commit_valid;
    logic [4:0] commit_ard;
    logic [6:0] commit_pd;
    logic       flush;

    int tests = 0;
    int fails = 0;

    // reference model
    int m_spec [32];
    int m_comm [32];
    bit m_valid;
    int m_ps1, m_ps2, m_pd, m_old, m_ard;
    bit m_rdwr;
    bit exp_ready, exp_pop, act_ready, act_pop;

    rename_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
        .fl_pop(fl_pop), .fl_pop_ok(fl_pop_ok), .fl_phy_rd(fl_phy_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
        .out_ard(out_ard), .out_rd_wr(out_rd_wr),
        .commit_valid(commit_valid), .commit_ard(commit_ard), .commit_pd(commit_pd),
        .flush(flush)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wr = 0;
        fl_pop_ok = 1; fl_phy_rd = 0; out_ready = 1;
        commit_valid = 0; commit_ard = 0; commit_pd = 0; flush = 0;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input bit wr, input int fl);
        in_valid = 1; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0]; in_rd = rd[4:0];
        in_rd_wr = wr; fl_phy_rd = fl[6:0];
    endtask

    // One clock: sample handshakes just before the edge, advance model at the edge.
    task automatic step();
        bit weff, acc;
        #1;
        weff = in_rd_wr && (in_rd != 0);
        exp_ready = !flush && (!m_valid || out_ready) && (!weff || fl_pop_ok);
        acc = in_valid && exp_ready;
        exp_pop = acc && weff;
        act_ready = in_ready;
        act_pop = fl_pop;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_spec[i] = i; m_comm[i] = i; end
            m_valid = 0; m_ps1 = 0; m_ps2 = 0; m_pd = 0; m_old = 0; m_ard = 0; m_rdwr = 0;
        end else begin
            if (commit_valid && commit_ard != 0) m_comm[commit_ard] = commit_pd;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_spec[i] = m_comm[i];
                m_valid = 0;
            end else if (acc) begin
                m_ps1 = m_spec[in_rs1];
                m_ps2 = m_spec[in_rs2];
                m_old = m_spec[in_rd];
                m_pd = weff ? int'(fl_phy_rd) : 0;
                m_ard = in_rd;
                m_rdwr = weff;
                if (weff) m_spec[in_rd] = fl_phy_rd;
                m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if (out_valid !== 1'b0 || fl_pop !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: out_valid=%0b fl_pop=%0b required 0 0", out_valid, fl_pop);
        end
        tests++;
        if ({out_ps1, out_ps2, out_pd, out_old_pd, out_ard, out_rd_wr} !== '0) begin
            fails++; $display("FAIL reset_data: ps1=%0d ps2=%0d pd=%0d old=%0d ard=%0d wr=%0b required all 0",
                              out_ps1, out_ps2, out_pd, out_old_pd, out_ard, out_rd_wr);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        issue(5, 7, 3, 1, 32);
        step();
        tests++;
        if (act_pop !== 1'b1 || act_ready !== 1'b1) begin
            fails++; $display("FAIL basic_pop: pop=%0b ready=%0b required 1 1", act_pop, act_ready);
        end
        tests++;
        if (out_valid !== 1 || out_ps1 !== 5 || out_ps2 !== 7 || out_pd !== 32 || out_old_pd !== 3 || out_ard !== 3 || out_rd_wr !== 1) begin
            fails++; $display("FAIL basic_out: v=%0b ps1=%0d ps2=%0d pd=%0d old=%0d ard=%0d wr=%0b required 1 5 7 32 3 3 1",
                              out_valid, out_ps1, out_ps2, out_pd, out_old_pd, out_ard, out_rd_wr);
        end
        idle();
        step();
        tests++;
        if (act_pop !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_once: pop=%0b out_valid=%0b required 0 0", act_pop, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        issue(1, 2, 3, 1, 32);
        step();
        issue(3, 0, 3, 1, 33);
        step();
        tests++;
        if (out_ps1 !== 32 || out_old_pd !== 32 || out_pd !== 33 || out_ps2 !== 0) begin
            fails++; $display("FAIL chain: ps1=%0d old=%0d pd=%0d ps2=%0d required 32 32 33 0", out_ps1, out_old_pd, out_pd, out_ps2);
        end
        idle();
        step();
    endtask

    task automatic test_no_free();
        apply_reset();
        fl_pop_ok = 0;
        issue(1, 2, 5, 1, 77);
        step();
        tests++;
        if (act_ready !== 0 || act_pop !== 0 || out_valid !== 0) begin
            fails++; $display("FAIL nofree_block: ready=%0b pop=%0b out_valid=%0b required 0 0 0", act_ready, act_pop, out_valid);
        end
        issue(4, 6, 0, 1, 77);
        step();
        tests++;
        if (act_ready !== 1 || act_pop !== 0 || out_valid !== 1 || out_pd !== 0 || out_rd_wr !== 0 || out_ps1 !== 4) begin
            fails++; $display("FAIL nofree_x0: ready=%0b pop=%0b v=%0b pd=%0d wr=%0b ps1=%0d required 1 0 1 0 0 4",
                              act_ready, act_pop, out_valid, out_pd, out_rd_wr, out_ps1);
        end
        issue(8, 9, 9, 0, 77);
        step();
        tests++;
        if (act_pop !== 0 || out_valid !== 1 || out_pd !== 0 || out_rd_wr !== 0 || out_old_pd !== 9 || out_ard !== 9) begin
            fails++; $display("FAIL nofree_nowr: pop=%0b v=%0b pd=%0d wr=%0b old=%0d ard=%0d required 0 1 0 0 9 9",
                              act_pop, out_valid, out_pd, out_rd_wr, out_old_pd, out_ard);
        end
        idle();
        step();
    endtask

    task automatic test_stall();
        apply_reset();
        issue(1, 2, 10, 1, 60);
        step();
        issue(10, 0, 11, 1, 61);
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (act_ready !== 0 || act_pop !== 0 || out_valid !== 1 || out_pd !== 60 || out_ard !== 10 || out_ps1 !== 1) begin
                fails++; $display("FAIL stall_hold[%0d]: ready=%0b pop=%0b v=%0b pd=%0d ard=%0d ps1=%0d required 0 0 1 60 10 1",
                                  k, act_ready, act_pop, out_valid, out_pd, out_ard, out_ps1);
            end
        end
        out_ready = 1;
        step();
        tests++;
        if (act_ready !== 1 || act_pop !== 1 || out_pd !== 61 || out_ps1 !== 60 || out_old_pd !== 11) begin
            fails++; $display("FAIL stall_release: ready=%0b pop=%0b pd=%0d ps1=%0d old=%0d required 1 1 61 60 11",
                              act_ready, act_pop, out_pd, out_ps1, out_old_pd);
        end
        idle();
        step();
    endtask

    task automatic test_flush_commit();
        apply_reset();
        issue(0, 0, 4, 1, 40);
        step();
        issue(0, 0, 4, 1, 41);
        commit_valid = 1; commit_ard = 4; commit_pd = 40;
        step();
        commit_valid = 0;
        issue(1, 1, 5, 1, 90);
        flush = 1;
        step();
        tests++;
        if (act_ready !== 0 || act_pop !== 0 || out_valid !== 0) begin
            fails++; $display("FAIL flush_block: ready=%0b pop=%0b v=%0b required 0 0 0", act_ready, act_pop, out_valid);
        end
        flush = 0;
        issue(4, 5, 0, 0, 0);
        step();
        tests++;
        if (out_valid !== 1 || out_ps1 !== 40 || out_ps2 !== 5) begin
            fails++; $display("FAIL flush_restore: v=%0b ps1=%0d ps2=%0d required 1 40 5", out_valid, out_ps1, out_ps2);
        end
        idle();
        step();
    endtask

    task automatic test_flush_same_cycle_commit();
        apply_reset();
        issue(0, 0, 6, 1, 45);
        step();
        idle();
        commit_valid = 1; commit_ard = 6; commit_pd = 50;
        flush = 1;
        step();
        idle();
        issue(6, 4, 0, 0, 0);
        step();
        tests++;
        if (out_ps1 !== 50 || out_ps2 !== 4) begin
            fails++; $display("FAIL flush_commit_same: ps1=%0d ps2=%0d required 50 4", out_ps1, out_ps2);
        end
        idle();
        commit_valid = 1; commit_ard = 0; commit_pd = 99;
        flush = 1;
        step();
        idle();
        issue(0, 0, 0, 1, 0);
        step();
        tests++;
        if (out_ps1 !== 0 || out_old_pd !== 0) begin
            fails++; $display("FAIL commit_x0: ps1=%0d old=%0d required 0 0", out_ps1, out_old_pd);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs1 = $urandom_range(0, 31);
            in_rs2 = $urandom_range(0, 31);
            in_rd = $urandom_range(0, 31);
            in_rd_wr = ($urandom_range(0, 3) != 0);
            fl_pop_ok = ($urandom_range(0, 4) != 0);
            fl_phy_rd = $urandom_range(32, 127);
            out_ready = ($urandom_range(0, 3) != 0);
            commit_valid = ($urandom_range(0, 3) == 0);
            commit_ard = $urandom_range(0, 31);
            commit_pd = $urandom_range(0, 127);
            flush = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
            tests++;
            if (act_ready !== exp_ready || act_pop !== exp_pop) begin
                fails++; $display("FAIL rand_hs[%0d]: ready=%0b pop=%0b required %0b %0b", n, act_ready, act_pop, exp_ready, exp_pop);
            end
            tests++;
            if (out_valid !== m_valid || out_ps1 !== m_ps1[6:0] || out_ps2 !== m_ps2[6:0] || out_pd !== m_pd[6:0] ||
                out_old_pd !== m_old[6:0] || out_ard !== m_ard[4:0] || out_rd_wr !== m_rdwr) begin
                fails++; $display("FAIL rand_out[%0d]: v=%0b ps1=%0d ps2=%0d pd=%0d old=%0d ard=%0d wr=%0b required %0b %0d %0d %0d %0d %0d %0b",
                                  n, out_valid, out_ps1, out_ps2, out_pd, out_old_pd, out_ard, out_rd_wr,
                                  m_valid, m_ps1, m_ps2, m_pd, m_old, m_ard, m_rdwr);
            end
        end
        rst = 0;
        // reset while flush, commit and an accept are all requested
        issue(1, 2, 3, 1, 100);
        commit_valid = 1; commit_ard = 3; commit_pd = 101; flush = 1; out_ready = 1;
        rst = 1;
        step();
        rst = 0;
        idle();
        issue(3, 2, 0, 0, 0);
        step();
        tests++;
        if (out_ps1 !== 3 || out_ps2 !== 2 || out_valid !== 1) begin
            fails++; $display("FAIL reset_mid: ps1=%0d ps2=%0d v=%0b required 3 2 1", out_ps1, out_ps2, out_valid);
        end
        idle();
        step();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_no_free();
        test_stall();
        test_flush_commit();
        test_flush_same_cycle_commit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
